// File: rtl/pdata_pkg.sv
// Shared types and constants for the serial MAC command sequencer.
package pdata_pkg;

   // Operand width of the attached serial MAC element; its accumulator is 4x this.
   localparam int SIZE_DEFAULT = 32;

   // Opcodes understood by the serial MAC element.
   typedef enum logic [2:0] {
      MAC_OUT_DATA1 = 3'd0,
      MAC_OUT_DATA2 = 3'd1,
      MAC_OUT_RES   = 3'd2,
      MAC_LOAD      = 3'd3,
      MAC_LOAD_RES  = 3'd4,
      MAC_MUL       = 3'd5,
      MAC_MUL_ADD   = 3'd6,
      MAC_NO_OP     = 3'd7
   } mac_op_e;

   // Commands accepted on the command channel.
   typedef enum logic [2:0] {
      CMD_LOAD     = 3'd0,
      CMD_MUL      = 3'd1,
      CMD_MUL_ADD  = 3'd2,
      CMD_READ_RES = 3'd3,
      CMD_LOAD_RES = 3'd4,
      CMD_READ_D1  = 3'd5,
      CMD_READ_D2  = 3'd6,
      CMD_NOP      = 3'd7
   } cmd_op_e;

   // Sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_PULSE = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   // MAC opcode driven while a command is being executed.
   function automatic mac_op_e macOpFor(input cmd_op_e op);
      mac_op_e result;
      case (op)
         CMD_LOAD:     result = MAC_LOAD;
         CMD_MUL:      result = MAC_MUL;
         CMD_MUL_ADD:  result = MAC_MUL_ADD;
         CMD_READ_RES: result = MAC_OUT_RES;
         CMD_LOAD_RES: result = MAC_LOAD_RES;
         CMD_READ_D1:  result = MAC_OUT_DATA1;
         CMD_READ_D2:  result = MAC_OUT_DATA2;
         default:      result = MAC_NO_OP;
      endcase
      return result;
   endfunction

   // Commands that loop MAC content back and return it as a response.
   function automatic logic isReadOp(input cmd_op_e op);
      return (op == CMD_READ_RES) || (op == CMD_READ_D1) || (op == CMD_READ_D2);
   endfunction

endpackage

// File: rtl/pdata_if.sv
// Command/response channel between a host and the MAC sequencer.
interface pdata_if #(
   parameter int SIZE = pdata_pkg::SIZE_DEFAULT
);
   logic                cmd_valid;
   logic                cmd_ready;
   logic [2:0]          cmd_op;
   logic [SIZE-1:0]     cmd_data;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [4*SIZE-1:0]   rsp_data;

   modport master (
      output cmd_valid, cmd_op, cmd_data, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/pdata_shreg.sv
// Parallel-load shift register, shifting MSB-first (serial in at the LSB).
module pdata_shreg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             nRst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] loadVal_i,
   input  logic             shift_i,
   input  logic             serIn_i,
   output logic             serOut_o,
   output logic [WIDTH-1:0] par_o
);

   logic [WIDTH-1:0] shift_q;

   // Load has priority over shift so a fresh command always starts clean.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         shift_q <= '0;
      end else if (load_i) begin
         shift_q <= loadVal_i;
      end else if (shift_i) begin
         shift_q <= {shift_q[WIDTH-2:0], serIn_i};
      end
   end

   assign serOut_o = shift_q[WIDTH-1];
   assign par_o    = shift_q;

endmodule

// File: rtl/pdata_seq.sv
// Command sequencer driving a bit-serial MAC element: serializes loads,
// loops reads back through the element while capturing them, pulses MUL ops.
module pdata_seq
   import pdata_pkg::*;
#(
   parameter int SIZE = SIZE_DEFAULT
) (
   input  logic       clk,
   input  logic       nRst,
   pdata_if.slave     bus,
   output logic [2:0] opcode,
   output logic       rx,
   input  logic       tx,
   output logic       busy
);

   localparam int W  = 4 * SIZE;
   localparam int CW = $clog2(W);
   localparam logic [CW-1:0] CNT_WORD = CW'(SIZE - 1);
   localparam logic [CW-1:0] CNT_WIDE = CW'(W - 1);

   state_e          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   cmd_op_e         op_q, op_d;
   logic [W-1:0]    rsp_data_q;

   cmd_op_e         cmdOp;
   logic            opIsRead;
   mac_op_e         macOp;
   logic            rxBit;

   logic            serLoad;
   logic [W-1:0]    serLoadVal;
   logic            serShift;
   logic            serMsb;
   logic [W-1:0]    serPar;

   logic            capLoad;
   logic            capShift;
   logic            capSer;
   logic [W-1:0]    capPar;
   logic            rspLoad;

   assign cmdOp    = cmd_op_e'(bus.cmd_op);
   assign opIsRead = isReadOp(op_q);

   pdata_shreg #(.WIDTH(W)) serializer (
      .clk       (clk),
      .nRst      (nRst),
      .load_i    (serLoad),
      .loadVal_i (serLoadVal),
      .shift_i   (serShift),
      .serIn_i   (1'b0),
      .serOut_o  (serMsb),
      .par_o     (serPar)
   );

   pdata_shreg #(.WIDTH(W)) capture (
      .clk       (clk),
      .nRst      (nRst),
      .load_i    (capLoad),
      .loadVal_i ('0),
      .shift_i   (capShift),
      .serIn_i   (tx),
      .serOut_o  (capSer),
      .par_o     (capPar)
   );

   // Next-state logic and all MAC-side outputs; everything defaults to idle.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      op_d       = op_q;
      serLoad    = 1'b0;
      serLoadVal = '0;
      serShift   = 1'b0;
      capLoad    = 1'b0;
      capShift   = 1'b0;
      rspLoad    = 1'b0;
      macOp      = MAC_NO_OP;
      rxBit      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid) begin
               op_d    = cmdOp;
               serLoad = 1'b1;
               capLoad = 1'b1;
               case (cmdOp)
                  CMD_LOAD: begin
                     serLoadVal = {bus.cmd_data, {(3*SIZE){1'b0}}};
                     count_d    = CNT_WORD;
                     state_d    = ST_SHIFT;
                  end
                  CMD_LOAD_RES: begin
                     serLoadVal = {{(3*SIZE){1'b0}}, bus.cmd_data};
                     count_d    = CNT_WIDE;
                     state_d    = ST_SHIFT;
                  end
                  CMD_READ_D1, CMD_READ_D2: begin
                     count_d = CNT_WORD;
                     state_d = ST_SHIFT;
                  end
                  CMD_READ_RES: begin
                     count_d = CNT_WIDE;
                     state_d = ST_SHIFT;
                  end
                  CMD_MUL, CMD_MUL_ADD: begin
                     state_d = ST_PULSE;
                  end
                  default: begin
                     state_d = ST_IDLE;
                  end
               endcase
            end
         end
         ST_SHIFT: begin
            macOp = macOpFor(op_q);
            if (opIsRead) begin
               rxBit    = tx;
               capShift = 1'b1;
            end else begin
               rxBit    = serMsb;
               serShift = 1'b1;
            end
            if (count_q == '0) begin
               rspLoad = opIsRead;
               state_d = opIsRead ? ST_RESP : ST_IDLE;
            end else begin
               count_d = count_q - CW'(1);
            end
         end
         ST_PULSE: begin
            macOp   = macOpFor(op_q);
            state_d = ST_IDLE;
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sequencer state, shift counter and the command being executed.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         op_q    <= CMD_NOP;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         op_q    <= op_d;
      end
   end

   // Response register includes the bit captured on the final shift edge and
   // holds across handshakes until the next read completes.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         rsp_data_q <= '0;
      end else if (rspLoad) begin
         rsp_data_q <= {capPar[W-2:0], tx};
      end
   end

   assign opcode        = macOp;
   assign rx            = rxBit;
   assign busy          = (state_q != ST_IDLE);
   assign bus.cmd_ready = (state_q == ST_IDLE);
   assign bus.rsp_valid = (state_q == ST_RESP);
   assign bus.rsp_data  = rsp_data_q;

   logic unused_ok;
   assign unused_ok = &{1'b0, serPar, capSer, capPar[W-1]};

endmodule

// File: tb/tb_pdata_seq.sv
// Bench for pdata_seq: bit-level MAC element model on the serial side and an
// operand-level reference model predicting every read response.
module tb_pdata_seq;
   import pdata_pkg::*;

   localparam int SIZE  = 32;
   localparam int W     = 4 * SIZE;
   localparam int LIMIT = 400;

   logic       clk  = 1'b0;
   logic       nRst = 1'b0;
   logic [2:0] opcode;
   logic       rx;
   logic       tx;
   logic       busy;

   int checks = 0;
   int errors = 0;

   logic [SIZE-1:0] macD1, macD2;
   logic [W-1:0]    macRes;

   logic [SIZE-1:0] mD1, mD2;
   logic [W-1:0]    mRes;

   pdata_if #(.SIZE(SIZE)) bus ();

   pdata_seq #(.SIZE(SIZE)) dut (
      .clk    (clk),
      .nRst   (nRst),
      .bus    (bus),
      .opcode (opcode),
      .rx     (rx),
      .tx     (tx),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   // Serial MAC element: shifts on its opcode, multiplies on MUL/MUL_ADD.
   always @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         macD1  <= '0;
         macD2  <= '0;
         macRes <= '0;
      end else begin
         case (opcode)
            3'd0: macD1 <= {macD1[SIZE-2:0], rx};
            3'd1: macD2 <= {macD2[SIZE-2:0], rx};
            3'd2, 3'd4: macRes <= {macRes[W-2:0], rx};
            3'd3: begin
               macD1 <= {macD1[SIZE-2:0], rx};
               macD2 <= {macD2[SIZE-2:0], macD1[SIZE-1]};
            end
            3'd5: macRes <= W'(macD1) * W'(macD2);
            3'd6: macRes <= macRes + W'(macD1) * W'(macD2);
            default: ;
         endcase
      end
   end

   // MAC serial output is the MSB of whichever register the opcode selects.
   always_comb begin
      case (opcode)
         3'd0:    tx = macD1[SIZE-1];
         3'd1:    tx = macD2[SIZE-1];
         3'd2:    tx = macRes[W-1];
         default: tx = 1'b0;
      endcase
   end

   task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic modelUpdate(input logic [2:0] op, input logic [SIZE-1:0] data,
                              output logic [W-1:0] expRsp);
      expRsp = '0;
      case (op)
         3'd0: begin mD2 = mD1; mD1 = data; end
         3'd1: mRes = W'(mD1) * W'(mD2);
         3'd2: mRes = mRes + W'(mD1) * W'(mD2);
         3'd3: expRsp = mRes;
         3'd4: mRes = W'(data);
         3'd5: expRsp = W'(mD1);
         3'd6: expRsp = W'(mD2);
         default: ;
      endcase
   endtask

   task automatic waitReady(input string tag);
      int guard = 0;
      while (bus.cmd_ready !== 1'b1 && guard < LIMIT) begin
         @(negedge clk);
         guard++;
      end
      checkOutput(tag, W'(guard < LIMIT), W'(1));
   endtask

   // Issues one command at a negedge; for reads, optionally stalls rsp_ready
   // for holdCycles while offering a command that must be ignored.
   task automatic applyStimulus(input logic [2:0] op, input logic [SIZE-1:0] data,
                                input int holdCycles, output logic [W-1:0] rsp);
      logic [W-1:0] expRsp;
      int guard;
      waitReady("cmd_ready_wait");
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_data  = data;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 3'd7;
      bus.cmd_data  = $urandom;
      modelUpdate(op, data, expRsp);
      rsp = '0;
      if (op == 3'd3 || op == 3'd5 || op == 3'd6) begin
         guard = 0;
         while (bus.rsp_valid !== 1'b1 && guard < LIMIT) begin
            @(negedge clk);
            guard++;
         end
         checkOutput("rsp_valid_wait", W'(guard < LIMIT), W'(1));
         rsp = bus.rsp_data;
         checkOutput($sformatf("rsp_data_op%0d", op), rsp, expRsp);
         for (int i = 0; i < holdCycles; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = 3'd0;
            @(negedge clk);
            checkOutput("hold_rsp_valid", W'(bus.rsp_valid), W'(1));
            checkOutput("hold_rsp_data", bus.rsp_data, rsp);
            checkOutput("hold_cmd_ready", W'(bus.cmd_ready), W'(0));
            checkOutput("hold_opcode", W'(opcode), W'(7));
         end
         bus.cmd_valid = 1'b0;
         bus.cmd_op    = 3'd7;
         bus.rsp_ready = 1'b1;
         @(negedge clk);
         bus.rsp_ready = 1'b0;
         checkOutput("rsp_valid_drop", W'(bus.rsp_valid), W'(0));
         checkOutput("rsp_data_keep", bus.rsp_data, rsp);
      end
   endtask

   initial begin
      logic [W-1:0]    rsp;
      logic [SIZE-1:0] rxSeq;
      int              opBad;
      int              readyBad;
      logic [2:0]      rop;

      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 3'd7;
      bus.cmd_data  = '0;
      bus.rsp_ready = 1'b0;
      mD1 = '0; mD2 = '0; mRes = '0;

      #1;
      checkOutput("reset_cmd_ready", W'(bus.cmd_ready), W'(1));
      checkOutput("reset_busy", W'(busy), W'(0));
      checkOutput("reset_opcode", W'(opcode), W'(7));
      checkOutput("reset_rx", W'(rx), W'(0));
      checkOutput("reset_rsp_valid", W'(bus.rsp_valid), W'(0));
      checkOutput("reset_rsp_data", bus.rsp_data, W'(0));
      @(negedge clk);
      nRst = 1'b1;
      @(negedge clk);

      $display("[TB] directed multiply sequence");
      applyStimulus(3'd0, 32'h3, 0, rsp);
      applyStimulus(3'd0, 32'h5, 0, rsp);
      applyStimulus(3'd1, 32'h0, 0, rsp);
      checkOutput("mul_pulse_opcode", W'(opcode), W'(5));
      checkOutput("mul_pulse_rx", W'(rx), W'(0));
      checkOutput("mul_pulse_busy", W'(busy), W'(1));
      @(negedge clk);
      checkOutput("mul_ready_k2", W'(bus.cmd_ready), W'(1));
      applyStimulus(3'd3, 32'h0, 0, rsp);
      checkOutput("read_res_mul", rsp, W'(32'h0F));
      applyStimulus(3'd3, 32'h0, 0, rsp);
      checkOutput("read_res_again", rsp, W'(32'h0F));
      applyStimulus(3'd2, 32'h0, 0, rsp);
      checkOutput("muladd_pulse_opcode", W'(opcode), W'(6));
      applyStimulus(3'd3, 32'h0, 0, rsp);
      checkOutput("read_res_muladd", rsp, W'(32'h1E));
      applyStimulus(3'd5, 32'h0, 0, rsp);
      checkOutput("read_d1", rsp, W'(32'h5));
      applyStimulus(3'd6, 32'h0, 0, rsp);
      checkOutput("read_d2", rsp, W'(32'h3));

      $display("[TB] LOAD serial timing");
      waitReady("load_timing_ready");
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 3'd0;
      bus.cmd_data  = 32'hDEADBEEF;
      modelUpdate(3'd0, 32'hDEADBEEF, rsp);
      rxSeq = '0; opBad = 0; readyBad = 0;
      for (int i = 1; i <= SIZE; i++) begin
         @(negedge clk);
         bus.cmd_valid = 1'b0;
         bus.cmd_data  = $urandom;
         rxSeq = {rxSeq[SIZE-2:0], rx};
         if (opcode !== 3'd3) opBad++;
         if (bus.cmd_ready !== 1'b0 || busy !== 1'b1) readyBad++;
      end
      checkOutput("load_rx_sequence", W'(rxSeq), W'(32'hDEADBEEF));
      checkOutput("load_opcode_cycles", W'(opBad), W'(0));
      checkOutput("load_ready_low", W'(readyBad), W'(0));
      @(negedge clk);
      checkOutput("load_ready_k33", W'(bus.cmd_ready), W'(1));
      checkOutput("load_opcode_done", W'(opcode), W'(7));

      $display("[TB] stalled response");
      applyStimulus(3'd3, 32'h0, 10, rsp);
      applyStimulus(3'd6, 32'h0, 0, rsp);
      checkOutput("read_d2_after_load", rsp, W'(32'h5));

      $display("[TB] reset during LOAD");
      waitReady("reset_load_ready");
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 3'd0;
      bus.cmd_data  = 32'hFFFFFFFF;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      repeat (9) @(negedge clk);
      checkOutput("pre_reset_opcode", W'(opcode), W'(3));
      checkOutput("pre_reset_rx", W'(rx), W'(1));
      nRst = 1'b0;
      mD1 = '0; mD2 = '0; mRes = '0;
      #1;
      checkOutput("mid_reset_opcode", W'(opcode), W'(7));
      checkOutput("mid_reset_rx", W'(rx), W'(0));
      checkOutput("mid_reset_busy", W'(busy), W'(0));
      checkOutput("mid_reset_rsp_data", bus.rsp_data, W'(0));
      @(negedge clk);
      nRst = 1'b1;
      checkOutput("post_reset_ready", W'(bus.cmd_ready), W'(1));
      @(negedge clk);
      checkOutput("post_reset_no_rsp", W'(bus.rsp_valid), W'(0));
      applyStimulus(3'd5, 32'h0, 0, rsp);

      $display("[TB] LOAD_RES and NOP");
      applyStimulus(3'd4, 32'h12345678, 0, rsp);
      applyStimulus(3'd3, 32'h0, 0, rsp);
      checkOutput("read_loaded_res", rsp, W'(32'h12345678));
      applyStimulus(3'd7, 32'h0, 0, rsp);
      checkOutput("nop_ready_next", W'(bus.cmd_ready), W'(1));
      checkOutput("nop_opcode", W'(opcode), W'(7));

      $display("[TB] random command stream");
      for (int n = 0; n < 30; n++) begin
         rop = 3'($urandom_range(0, 7));
         applyStimulus(rop, $urandom, (n % 7 == 3) ? 2 : 0, rsp);
      end
      applyStimulus(3'd3, 32'h0, 0, rsp);
      applyStimulus(3'd5, 32'h0, 0, rsp);
      applyStimulus(3'd6, 32'h0, 0, rsp);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
